// File: rtl/add_sub_select_7seg_pkg.sv
// Shared types and constants for the 4-bit add/subtract unit with a hex 7-segment display.
// Segment bit order is {g,f,e,d,c,b,a}, and a segment lights when its bit is 0.
package add_sub_select_7seg_pkg;

  localparam int DATA_W = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [DATA_W:0]   wide_t;
  typedef logic [6:0]        seg_t;

  // Active-low hex font, indexed by digit value 0..F.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam seg_t SEG_ZERO = 7'b1000000;

  // Everything the unit registers in one cycle.
  typedef struct packed {
    data_t add_res;
    logic  add_ovf;
    data_t sub_res;
    logic  sub_ovf;
    data_t result;
    seg_t  display;
  } out_regs_t;

  localparam out_regs_t OUT_RESET = '{
    add_res: '0, add_ovf: 1'b0, sub_res: '0, sub_ovf: 1'b0,
    result:  '0, display: SEG_ZERO
  };

endpackage

// File: rtl/add_sub_select_7seg_if.sv
// Bundles the operand and select inputs together with the registered result and display outputs.
interface add_sub_select_7seg_if;
  import add_sub_select_7seg_pkg::*;

  data_t A;
  data_t B;
  logic  S;
  seg_t  Display;
  data_t resultOfAddition;
  logic  overflowOfAddition;
  data_t resultOfSubtraction;
  logic  overflowOfSubtraction;
  data_t result;

  modport master (
    output A, B, S,
    input  Display, resultOfAddition, overflowOfAddition,
           resultOfSubtraction, overflowOfSubtraction, result
  );

  modport slave (
    input  A, B, S,
    output Display, resultOfAddition, overflowOfAddition,
           resultOfSubtraction, overflowOfSubtraction, result
  );

endinterface

// File: rtl/add_sub_select_7seg_hex_to_7seg.sv
// Combinational decoder from a 4-bit value to an active-low hex segment pattern.
module hex_to_7seg
  import add_sub_select_7seg_pkg::*;
(
  input  data_t value_i,
  output seg_t  seg_o
);

  // The table covers all 16 codes, so every input maps to a defined pattern.
  always_comb begin
    seg_o = SEG_TABLE[value_i];
  end

endmodule

// File: rtl/add_sub_select_7seg.sv
// Registered 4-bit adder/subtractor. S picks which result is shown on a common-anode hex digit.
module add_sub_select_7seg
  import add_sub_select_7seg_pkg::*;
(
  input logic            clk,
  input logic            reset,
  add_sub_select_7seg_if.slave bus
);

  wide_t     sum_w;
  wide_t     diff_w;
  data_t     result_w;
  seg_t      display_w;
  out_regs_t regs_d;
  out_regs_t regs_q;

  // The display is decoded from the next-state result, so it is registered in the same cycle as result.
  hex_to_7seg u_hex_to_7seg (
    .value_i (result_w),
    .seg_o   (display_w)
  );

  // NOTE: assign every signal a default at the top of always_comb. A path that leaves a signal unassigned infers a latch.
  always_comb begin
    regs_d   = OUT_RESET;
    sum_w    = {1'b0, bus.A} + {1'b0, bus.B};
    diff_w   = {1'b0, bus.A} - {1'b0, bus.B};
    result_w = bus.S ? sum_w[DATA_W-1:0] : diff_w[DATA_W-1:0];

    regs_d.add_res = sum_w[DATA_W-1:0];
    regs_d.add_ovf = sum_w[DATA_W];
    regs_d.sub_res = diff_w[DATA_W-1:0];
    regs_d.sub_ovf = diff_w[DATA_W];
    regs_d.result  = result_w;
    regs_d.display = display_w;
  end

  // NOTE: use non-blocking assignments for clocked state so that every register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= OUT_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.resultOfAddition      = regs_q.add_res;
  assign bus.overflowOfAddition    = regs_q.add_ovf;
  assign bus.resultOfSubtraction   = regs_q.sub_res;
  assign bus.overflowOfSubtraction = regs_q.sub_ovf;
  assign bus.result                = regs_q.result;
  assign bus.Display               = regs_q.display;

endmodule

// File: tb/tb_add_sub_select_7seg.sv
// Self-checking bench: an arithmetic reference model is compared on every clock, alongside hand-computed expectations.
module tb_add_sub_select_7seg;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  add_sub_select_7seg_if bus_if ();

  add_sub_select_7seg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hex font is written out independently of the RTL package.
  logic [6:0] font [16];
  initial begin
    font[0]  = 7'b1000000; font[1]  = 7'b1111001; font[2]  = 7'b0100100; font[3]  = 7'b0110000;
    font[4]  = 7'b0011001; font[5]  = 7'b0010010; font[6]  = 7'b0000010; font[7]  = 7'b1111000;
    font[8]  = 7'b0000000; font[9]  = 7'b0010000; font[10] = 7'b0001000; font[11] = 7'b0000011;
    font[12] = 7'b1000110; font[13] = 7'b0100001; font[14] = 7'b0000110; font[15] = 7'b0001110;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated from the inputs sampled at each rising edge, then checked 1 time unit later.
  always begin
    int a, b, s, rst;
    int e_add, e_ovfa, e_sub, e_ovfs, e_res;
    logic [6:0] e_disp;
    @(posedge clk);
    a = int'(bus_if.A); b = int'(bus_if.B); s = int'(bus_if.S); rst = int'(reset);
    if (rst != 0) begin
      e_add = 0; e_ovfa = 0; e_sub = 0; e_ovfs = 0; e_res = 0;
    end else begin
      e_add  = (a + b) % 16;
      e_ovfa = (a + b > 15) ? 1 : 0;
      e_sub  = (a - b + 16) % 16;
      e_ovfs = (b > a) ? 1 : 0;
      e_res  = (s != 0) ? e_add : e_sub;
    end
    e_disp = font[e_res];
    #1;
    check("model_add",  8'(bus_if.resultOfAddition),      8'(e_add));
    check("model_ovfa", 8'(bus_if.overflowOfAddition),    8'(e_ovfa));
    check("model_sub",  8'(bus_if.resultOfSubtraction),   8'(e_sub));
    check("model_ovfs", 8'(bus_if.overflowOfSubtraction), 8'(e_ovfs));
    check("model_res",  8'(bus_if.result),                8'(e_res));
    check("model_disp", 8'(bus_if.Display),               8'(e_disp));
  end

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic s, input logic r);
    @(negedge clk);
    bus_if.A = a; bus_if.B = b; bus_if.S = s; reset = r;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_all(input string tag, input logic [3:0] add, input logic ovfa,
                            input logic [3:0] sub, input logic ovfs,
                            input logic [3:0] res, input logic [6:0] disp);
    check({tag, "_add"},  8'(bus_if.resultOfAddition),      8'(add));
    check({tag, "_ovfa"}, 8'(bus_if.overflowOfAddition),    8'(ovfa));
    check({tag, "_sub"},  8'(bus_if.resultOfSubtraction),   8'(sub));
    check({tag, "_ovfs"}, 8'(bus_if.overflowOfSubtraction), 8'(ovfs));
    check({tag, "_res"},  8'(bus_if.result),                8'(res));
    check({tag, "_disp"}, 8'(bus_if.Display),               8'(disp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus_if.A = 4'hF; bus_if.B = 4'h1; bus_if.S = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    expect_all("reset", 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 7'b1000000);

    step(4'hF, 4'h1, 1'b1, 1'b0);
    expect_all("post_reset", 4'h0, 1'b1, 4'hE, 1'b0, 4'h0, 7'b1000000);

    step(4'hF, 4'h1, 1'b0, 1'b0);
    expect_all("sub_path", 4'h0, 1'b1, 4'hE, 1'b0, 4'hE, 7'b0000110);

    step(4'h0, 4'h1, 1'b0, 1'b0);
    expect_all("borrow", 4'h1, 1'b0, 4'hF, 1'b1, 4'hF, 7'b0001110);

    step(4'h0, 4'h1, 1'b1, 1'b0);
    expect_all("borrow_sel_add", 4'h1, 1'b0, 4'hF, 1'b1, 4'h1, 7'b1111001);

    step(4'hF, 4'hF, 1'b1, 1'b0);
    expect_all("carry", 4'hE, 1'b1, 4'h0, 1'b0, 4'hE, 7'b0000110);

    step(4'h0, 4'hF, 1'b0, 1'b0);
    expect_all("a0_bf", 4'hF, 1'b0, 4'h1, 1'b1, 4'h1, 7'b1111001);

    step(4'h7, 4'h7, 1'b0, 1'b0);
    expect_all("a_eq_b", 4'hE, 1'b0, 4'h0, 1'b0, 4'h0, 7'b1000000);

    // Inputs change every cycle, with a single-cycle reset in the middle of the sequence.
    for (int i = 0; i < 30; i++) begin
      step(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0);
    end
    step(4'h9, 4'h3, 1'b1, 1'b1);
    expect_all("mid_reset", 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 7'b1000000);
    step(4'h9, 4'h3, 1'b1, 1'b0);
    expect_all("resume", 4'hC, 1'b0, 4'h6, 1'b0, 4'hC, 7'b1000110);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          step(4'(a), 4'(b), 1'(s), 1'b0);
        end
      end
    end

    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
           ($urandom_range(19) == 0));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
